dm_responder: RTL and testbench
===============================

DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning number of 32-bit words in the data memory.
REQ-002 SHALL have parameter LATENCY, default 2, meaning wait cycles between request acceptance and response (0..15).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning byte address of word 0.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous active-low reset, sampled on rising clk edge.
REQ-006 SHALL have port req_valid  input  1  CPU request present.
REQ-007 SHALL have port req_ready  output  1  responder accepts request this cycle.
REQ-008 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_be  input  4  byte enables for stores; bit i selects wdata[8i+7:8i].
REQ-011 SHALL have port req_wdata  input  32  store data.
REQ-012 SHALL have port rsp_valid  output  1  response present.
REQ-013 SHALL have port rsp_ready  input  1  CPU consumes response.
REQ-014 SHALL have port rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-015 SHALL have port rsp_err  output  1  misaligned or out-of-range access.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP; one outstanding request max.
REQ-017 req_ready SHALL be 1 exactly when state==IDLE and reset is high.
REQ-018 Handshake: request accepted on edge where req_valid && req_ready; addr/we/be/wdata captured at that edge.
REQ-019 IDLE -> WAIT on accept when LATENCY>0 (counter loaded LATENCY-1); IDLE -> RESP on accept when LATENCY==0.
REQ-020 WAIT: counter decrements each cycle; at 0 -> RESP; rsp_valid first high LATENCY+1 cycles after accept edge.
REQ-021 RESP: rsp_valid=1, rsp_rdata/rsp_err stable until rsp_valid && rsp_ready edge, then -> IDLE.
REQ-022 No back-to-back accept: minimum request spacing is LATENCY+2 cycles with rsp_ready held high.
REQ-023 Error = captured addr[1:0]!=0, or addr<BASE_ADDR, or (addr-BASE_ADDR)>=DEPTH_WORDS*4; 32-bit unsigned arithmetic.
REQ-024 Store without error SHALL update enabled bytes of word (addr-BASE_ADDR)>>2 on the edge entering RESP; disabled bytes unchanged.
REQ-025 Store with req_be==0 SHALL change nothing and report rsp_err=0.
REQ-026 Errored store SHALL not modify memory; errored load returns rsp_rdata=0.
REQ-027 Load data SHALL be sampled from memory on the edge entering RESP (reflects all earlier committed stores).
REQ-028 req_valid while not in IDLE SHALL be ignored (no capture, no side effect).

Reset
REQ-029 While reset==0: state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0.
REQ-030 Reset SHALL clear all memory words to 0.
REQ-031 Reset mid-operation (WAIT or RESP) SHALL abort: uncommitted store discarded, pending response dropped.
REQ-032 First accept possible on first rising edge after reset returns high.

Structure
REQ-033 Shared package dm_pkg SHALL hold state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2) and the error-check width constants.
REQ-034 Byte-enabled storage SHALL be sub-module dm_ram_array (ports clk, reset, we, be, word index, wdata, rdata).
REQ-035 FSM, counter, range check and response registers SHALL live in dm_responder.

Verification
REQ-036 Reset, store addr 0x0000_0010 be=4'hF wdata=0x1234_5678, then load 0x10 -> rsp_valid 3 cycles after each accept, rdata=0x1234_5678, err=0.
REQ-037 Store 0x10 be=4'b0010 wdata=0x0000_AB00 after REQ-036 data, load 0x10 -> rdata=0x1234_AB78.
REQ-038 Load 0x0000_0013 and load 0x0000_1000 (DEPTH 1024) -> rsp_err=1, rdata=0; store 0x1000 leaves memory unchanged.
REQ-039 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rdata stable, req_ready=0, second req_valid ignored; drop to IDLE one cycle after rsp_ready=1.
REQ-040 Store 0x20 accepted, reset low during WAIT, release, load 0x20 -> rdata=0, no stale rsp_valid after reset.
REQ-041 LATENCY=0 build: accept load at edge T -> rsp_valid high from edge T+1.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, bus widths
// and the access legality check used when a request reaches its response.
package dm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dm_state_e;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int BE_W       = 4;
    localparam int ALIGN_BITS = 2;
    localparam int CNT_W      = 4;

    // Word aligned and inside [base, base+span); all arithmetic is 32-bit unsigned.
    function automatic logic access_err(
        input logic [ADDR_W-1:0] addr,
        input logic [ADDR_W-1:0] base,
        input logic [ADDR_W-1:0] span
    );
        logic [ADDR_W-1:0] offset;
        offset = addr - base;
        return (addr[ALIGN_BITS-1:0] != '0) || (addr < base) || (offset >= span);
    endfunction

endpackage

// File: rtl/dm_ram_array.sv
// Byte-lane data memory: one storage array per lane, asynchronous read, write
// gated per lane by the byte enables, whole array cleared by reset.
module dm_ram_array
    import dm_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [IDX_W-1:0]  word_idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    generate
        for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
            logic [7:0] lane_q [DEPTH_WORDS];

            always_ff @(posedge clk) begin
                if (!reset) begin
                    for (int w = 0; w < DEPTH_WORDS; w++) begin
                        lane_q[w] <= '0;
                    end
                end else if (we && be[gi]) begin
                    lane_q[word_idx] <= wdata[8*gi +: 8];
                end
            end

            assign rdata[8*gi +: 8] = lane_q[word_idx];
        end
    endgenerate

endmodule

// File: rtl/dm_responder.sv
// Single-outstanding data-memory responder: accepts one request, waits LATENCY
// cycles, commits stores / samples loads on the edge entering RESP, then holds
// the response until the CPU takes it.
module dm_responder
    import dm_pkg::*;
#(
    parameter int              DEPTH_WORDS = 1024,
    parameter int              LATENCY     = 2,
    parameter logic [31:0]     BASE_ADDR   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [BE_W-1:0]   req_be,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int                IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [ADDR_W-1:0] SPAN     = ADDR_W'(DEPTH_WORDS * 4);
    localparam logic [CNT_W-1:0]  CNT_LOAD = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

    dm_state_e         state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [BE_W-1:0]   be_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;

    logic              accept;
    logic              enter_resp;
    logic              eff_we;
    logic [ADDR_W-1:0] eff_addr;
    logic [BE_W-1:0]   eff_be;
    logic [DATA_W-1:0] eff_wdata;
    logic              eff_err;
    logic [ADDR_W-1:0] offset;
    logic [IDX_W-1:0]  word_idx;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] rsp_rdata_d;

    assign req_ready = (state_q == IDLE) && reset;
    assign accept    = req_valid && req_ready;

    // With zero latency RESP is entered on the accept edge itself, so the
    // request must be resolved from the live inputs rather than the capture.
    always_comb begin
        eff_we     = we_q;
        eff_addr   = addr_q;
        eff_be     = be_q;
        eff_wdata  = wdata_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                eff_we     = req_we;
                eff_addr   = req_addr;
                eff_be     = req_be;
                eff_wdata  = req_wdata;
                enter_resp = accept && (LATENCY == 0);
            end
            WAIT:    enter_resp = (cnt_q == '0);
            default: enter_resp = 1'b0;
        endcase
    end

    assign eff_err     = access_err(eff_addr, BASE_ADDR, SPAN);
    assign offset      = eff_addr - BASE_ADDR;
    assign word_idx    = IDX_W'(offset >> ALIGN_BITS);
    assign ram_we      = enter_resp && eff_we && !eff_err;
    assign rsp_rdata_d = (eff_we || eff_err) ? '0 : ram_rdata;

    dm_ram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_ram (
        .clk      (clk),
        .reset    (reset),
        .we       (ram_we),
        .be       (eff_be),
        .word_idx (word_idx),
        .wdata    (eff_wdata),
        .rdata    (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        be_q    <= req_be;
                        wdata_q <= req_wdata;
                        if (LATENCY == 0) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (enter_resp) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= rsp_rdata_d;
                rsp_err_q   <= eff_err;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: a LATENCY=2 and a LATENCY=0 instance, each checked
// every cycle against a transaction-level model plus directed literal checks.
module tb_dm_responder;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic [1:0]  rst_n;
    logic [1:0]  req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr [2];
    logic [31:0] req_wdata [2];
    logic [31:0] rsp_rdata [2];
    logic [3:0]  req_be [2];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dm_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2), .BASE_ADDR(BASE)) dut_l2 (
        .clk(clk), .reset(rst_n[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_be(req_be[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dm_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0), .BASE_ADDR(BASE)) dut_l0 (
        .clk(clk), .reset(rst_n[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_be(req_be[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    function automatic string tag(input int k);
        return (k == 0) ? "L2" : "L0";
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Transaction-level model: a request's outcome is fully decided at accept,
    // the response becomes visible LATENCY cycles later and lasts until taken.
    logic [31:0] mm [2][DEPTH];
    bit          pend [2];
    int          acc [2];
    logic [31:0] exp_rd [2];
    bit          exp_er [2];
    int          cyc = 0;

    task automatic model_accept(input int k);
        logic [31:0] a;
        bit          err;
        int          idx;
        a   = req_addr[k];
        err = (a % 4 != 0) || (a < BASE) || ((a - BASE) >= 32'(DEPTH * 4));
        idx = int'((a - BASE) / 4);
        exp_rd[k] = 32'h0;
        if (!err) begin
            if (req_we[k]) begin
                for (int b = 0; b < 4; b++)
                    if (req_be[k][b]) mm[k][idx][8*b +: 8] = req_wdata[k][8*b +: 8];
            end else begin
                exp_rd[k] = mm[k][idx];
            end
        end
        exp_er[k] = err;
        pend[k]   = 1'b1;
        acc[k]    = cyc;
    endtask

    always @(posedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n[k]) begin
                pend[k] = 1'b0;
                for (int w = 0; w < DEPTH; w++) mm[k][w] = 32'h0;
            end else if (!pend[k]) begin
                if (req_valid[k]) model_accept(k);
            end else if (cyc >= acc[k] + lat_of(k) + 1 && rsp_ready[k]) begin
                pend[k] = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            bit exp_v;
            exp_v = pend[k] && (cyc >= acc[k] + lat_of(k));
            chk({tag(k), " req_ready"}, req_ready[k], rst_n[k] && !pend[k]);
            chk({tag(k), " rsp_valid"}, rsp_valid[k], exp_v);
            if (exp_v) begin
                chk({tag(k), " rsp_rdata"}, rsp_rdata[k], exp_rd[k]);
                chk({tag(k), " rsp_err"}, rsp_err[k], exp_er[k]);
            end
        end
    end

    task automatic txn(input int k, input bit now, input bit we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wd, input int hold,
                       output logic [31:0] rd, output logic er, output int lat, output int waits);
        int n;
        rd = 32'h0; er = 1'b0; lat = -1;
        if (!now) @(negedge clk);
        req_we[k] = we; req_addr[k] = addr; req_be[k] = be; req_wdata[k] = wd;
        req_valid[k] = 1'b1;
        rsp_ready[k] = (hold == 0);
        #1;
        n = 0;
        while (!req_ready[k] && n < 20) begin
            @(negedge clk); n++;
        end
        waits = n;
        chk({tag(k), " req_ready before accept"}, req_ready[k], 1);
        if (!req_ready[k]) begin
            req_valid[k] = 1'b0; rsp_ready[k] = 1'b1;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        if (hold > 0) begin
            req_addr[k] = ~addr; req_we[k] = ~we; req_wdata[k] = ~wd;
        end else begin
            req_valid[k] = 1'b0;
        end
        n = 0;
        while (!rsp_valid[k] && n < 40) begin
            @(negedge clk); n++;
        end
        chk({tag(k), " rsp_valid arrives"}, rsp_valid[k], 1);
        if (!rsp_valid[k]) begin
            req_valid[k] = 1'b0; rsp_ready[k] = 1'b1;
            return;
        end
        lat = n + 1;
        rd  = rsp_rdata[k];
        er  = rsp_err[k];
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            chk({tag(k), " req_ready while held"}, req_ready[k], 0);
            req_valid[k] = 1'b0;
            rsp_ready[k] = 1'b1;
        end
        @(negedge clk);
        chk({tag(k), " rsp_valid dropped"}, rsp_valid[k], 0);
        chk({tag(k), " idle after handshake"}, req_ready[k], 1);
        $display("[TB] %s %s addr=%h be=%h wd=%h -> rd=%h err=%0d lat=%0d",
                 tag(k), we ? "ST" : "LD", addr, be, wd, rd, er, lat);
    endtask

    task automatic rand_phase(input int k, input int count);
        logic [31:0] rd, a;
        logic        er;
        int          lat, w, r;
        for (int i = 0; i < count; i++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       a = BASE + 32'($urandom_range(0, 15) * 4);
            else if (r == 7) a = BASE + 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
            else if (r == 8) a = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 7) * 4);
            else             a = $urandom;
            txn(k, 1'b0, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom,
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, rd, er, lat, w);
            chk({tag(k), " random latency"}, lat, lat_of(k) + 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, w;

        rst_n = 2'b00; req_valid = 2'b00; req_we = 2'b00; rsp_ready = 2'b11;
        for (int k = 0; k < 2; k++) begin
            req_addr[k] = 32'h0; req_wdata[k] = 32'h0; req_be[k] = 4'h0;
        end
        repeat (3) @(negedge clk);
        chk("reset req_ready", req_ready[0], 0);
        chk("reset rsp_valid", rsp_valid[0], 0);
        chk("reset rsp_rdata", rsp_rdata[0], 32'h0);
        chk("reset rsp_err", rsp_err[0], 0);
        rst_n = 2'b11;

        // Full-word store then load.
        txn(0, 1'b0, 1'b1, 32'h10, 4'hF, 32'h1234_5678, 0, rd, er, lat, w);
        chk("store latency", lat, 3);
        chk("store err", er, 0);
        chk("store rdata", rd, 32'h0);
        txn(0, 1'b0, 1'b0, 32'h10, 4'h0, 32'h0, 0, rd, er, lat, w);
        chk("load latency", lat, 3);
        chk("load rdata", rd, 32'h1234_5678);
        chk("load err", er, 0);

        // Partial byte store.
        txn(0, 1'b0, 1'b1, 32'h10, 4'b0010, 32'h0000_AB00, 0, rd, er, lat, w);
        txn(0, 1'b0, 1'b0, 32'h10, 4'h0, 32'h0, 0, rd, er, lat, w);
        chk("byte merge rdata", rd, 32'h1234_AB78);

        // Misaligned and out-of-range accesses.
        txn(0, 1'b0, 1'b0, 32'h13, 4'h0, 32'h0, 0, rd, er, lat, w);
        chk("misaligned err", er, 1);
        chk("misaligned rdata", rd, 32'h0);
        txn(0, 1'b0, 1'b0, 32'h1000, 4'h0, 32'h0, 0, rd, er, lat, w);
        chk("out of range err", er, 1);
        chk("out of range rdata", rd, 32'h0);
        txn(0, 1'b0, 1'b1, 32'h1000, 4'hF, 32'hFFFF_FFFF, 0, rd, er, lat, w);
        chk("out of range store err", er, 1);
        txn(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 0, rd, er, lat, w);
        chk("word 0 untouched", rd, 32'h0);

        // Zero byte enables: no error, no change.
        txn(0, 1'b0, 1'b1, 32'h10, 4'h0, 32'hDEAD_BEEF, 0, rd, er, lat, w);
        chk("be=0 store err", er, 0);
        txn(0, 1'b0, 1'b0, 32'h10, 4'h0, 32'h0, 5, rd, er, lat, w);
        chk("held load rdata", rd, 32'h1234_AB78);
        chk("held load latency", lat, 3);

        // Reset during WAIT aborts the store; first accept right after release.
        @(negedge clk);
        req_we[0] = 1'b1; req_addr[0] = 32'h20; req_be[0] = 4'hF; req_wdata[0] = 32'hCAFE_F00D;
        req_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        rst_n[0] = 1'b0;
        @(negedge clk);
        chk("abort rsp_valid", rsp_valid[0], 0);
        chk("abort req_ready", req_ready[0], 0);
        rst_n[0] = 1'b1;
        txn(0, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 0, rd, er, lat, w);
        chk("first edge accept", w, 0);
        chk("aborted store discarded", rd, 32'h0);
        txn(0, 1'b0, 1'b0, 32'h10, 4'h0, 32'h0, 0, rd, er, lat, w);
        chk("reset cleared memory", rd, 32'h0);

        rand_phase(0, 150);

        // Zero-latency instance.
        txn(1, 1'b0, 1'b0, 32'h10, 4'h0, 32'h0, 0, rd, er, lat, w);
        chk("L0 load latency", lat, 1);
        chk("L0 load rdata", rd, 32'h0);
        txn(1, 1'b0, 1'b1, 32'h40, 4'b1001, 32'hAABB_CCDD, 0, rd, er, lat, w);
        chk("L0 store latency", lat, 1);
        txn(1, 1'b0, 1'b0, 32'h40, 4'h0, 32'h0, 2, rd, er, lat, w);
        chk("L0 byte store rdata", rd, 32'hAA00_00DD);
        txn(1, 1'b0, 1'b0, 32'h42, 4'h0, 32'h0, 0, rd, er, lat, w);
        chk("L0 misaligned err", er, 1);

        rand_phase(1, 100);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
